// File: rtl/bram_port_initiator.sv
// Initiator side of a BRAM port A: turns core req/gnt/rvalid transactions into
// BRAM strobes and realigns fixed-latency read data into in-order responses.
module bram_port_initiator #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  bram_clk_a,
  output logic                  bram_rst_a,
  output logic                  bram_en_a,
  output logic [3:0]            bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [31:0]           bram_wrdata_a,
  input  logic [31:0]           bram_rddata_a
);

  logic                    hit;
  logic                    acc_hit;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    rst_q;
  logic [READ_LATENCY-1:0] tag_v, tag_w, tag_e;
  logic [READ_LATENCY:0]   v_ext, w_ext, e_ext;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign bram_clk_a = clk;
  assign bram_rst_a = rst_q;

  assign gnt_o   = req_i && !stall_i && !reset;
  assign hit     = (addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign acc_hit = gnt_o && hit;

  // Misses are still accepted (they need an error response) but never reach memory.
  always_comb begin
    bram_en_a     = acc_hit;
    bram_we_a     = (acc_hit && we_i) ? be_i : '0;
    bram_addr_a   = addr_q;
    bram_wrdata_a = wdata_q;
    if (reset) begin
      bram_addr_a   = '0;
      bram_wrdata_a = '0;
    end else if (acc_hit) begin
      bram_addr_a   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
      bram_wrdata_a = wdata_i;
    end
  end

  // Extended vectors let the shift work for any latency, including 1.
  assign v_ext = {tag_v, gnt_o};
  assign w_ext = {tag_w, we_i};
  assign e_ext = {tag_e, !hit};

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      tag_v   <= '0;
      tag_w   <= '0;
      tag_e   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      tag_v <= v_ext[READ_LATENCY-1:0];
      tag_w <= w_ext[READ_LATENCY-1:0];
      tag_e <= e_ext[READ_LATENCY-1:0];
      if (acc_hit) begin
        addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= wdata_i;
      end
    end
  end

  // Gating with reset drops any response still in flight when reset arrives.
  assign rvalid_o = tag_v[READ_LATENCY-1] && !reset;
  assign err_o    = rvalid_o && tag_e[READ_LATENCY-1];
  assign rdata_o  = (rvalid_o && !tag_w[READ_LATENCY-1] && !tag_e[READ_LATENCY-1])
                    ? bram_rddata_a : '0;

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator with a 2-cycle-latency BRAM model.
module tb_bram_port_initiator;

  logic        clk = 1'b0;
  logic        reset, stall_i, req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        bram_clk_a, bram_rst_a, bram_en_a;
  logic [3:0]  bram_we_a;
  logic [15:0] bram_addr_a;
  logic [31:0] bram_wrdata_a, bram_rddata_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_port_initiator #(
    .READ_LATENCY(2),
    .BASE_ADDR   (32'h0000_0000),
    .ADDR_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .bram_clk_a   (bram_clk_a),
    .bram_rst_a   (bram_rst_a),
    .bram_en_a    (bram_en_a),
    .bram_we_a    (bram_we_a),
    .bram_addr_a  (bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a),
    .bram_rddata_a(bram_rddata_a)
  );

  // BRAM model: read-first, two register stages of read latency
  logic [31:0] mem [256];
  logic [31:0] rd1, rd2;
  assign bram_rddata_a = rd2;
  always @(posedge bram_clk_a) begin
    if (bram_en_a) begin
      rd1 <= mem[bram_addr_a[9:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) mem[bram_addr_a[9:2]][8*b +: 8] <= bram_wrdata_a[8*b +: 8];
    end
    rd2 <= bram_rst_a ? 32'h0 : rd1;
  end

  task automatic idle_inputs();
    req_i = 0; we_i = 0; stall_i = 0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; req_i = 1; addr_i = 32'h4; wdata_i = 32'h5555_5555; we_i = 1; be_i = 4'hF;
    @(negedge clk); @(negedge clk); #1;
    total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", gnt_o); end
    total++; if (bram_en_a !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", bram_en_a); end
    total++; if (bram_we_a !== 4'h0) begin bad++; $display("FAIL rst_we got=%h exp=0", bram_we_a); end
    total++; if (bram_addr_a !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bram_addr_a); end
    total++; if (bram_wrdata_a !== 32'h0) begin bad++; $display("FAIL rst_wrdata got=%h exp=0", bram_wrdata_a); end
    total++; if ({rvalid_o, err_o, rdata_o} !== 34'h0) begin bad++; $display("FAIL rst_resp got=%b/%b/%h exp=0/0/0", rvalid_o, err_o, rdata_o); end
    total++; if (bram_rst_a !== 1'b1) begin bad++; $display("FAIL rst_bram_rst got=%b exp=1", bram_rst_a); end
    idle_inputs(); reset = 0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (bram_rst_a !== 1'b0) begin bad++; $display("FAIL rst_bram_rst_rel got=%b exp=0", bram_rst_a); end
  endtask

  task automatic test_full_writes();
    logic [31:0] vals [5];
    vals = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hDEAD_BEEF, 32'h1122_3344};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_i = (i < 5); we_i = (i < 5); be_i = 4'hF;
      addr_i = 32'(i * 4); wdata_i = (i < 5) ? vals[i] : 32'h0;
      #1;
      if (i < 5) begin
        total++; if (bram_we_a !== 4'hF || bram_wrdata_a !== vals[i]) begin bad++; $display("FAIL wr_strobe[%0d] got=%h/%h exp=f/%h", i, bram_we_a, bram_wrdata_a, vals[i]); end
      end
      if (i >= 2 && i < 7) begin
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0 || err_o !== 1'b0) begin bad++; $display("FAIL wr_resp[%0d] got=%b/%h/%b exp=1/0/0", i, rvalid_o, rdata_o, err_o); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_read();
    @(negedge clk);
    req_i = 1; we_i = 0; addr_i = 32'h0000_000C; #1;
    total++; if (gnt_o !== 1'b1 || bram_en_a !== 1'b1 || bram_addr_a !== 16'h000C || bram_we_a !== 4'h0) begin
      bad++; $display("FAIL rd_issue got=%b/%b/%h/%h exp=1/1/000c/0", gnt_o, bram_en_a, bram_addr_a, bram_we_a); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_early got=%b exp=0", rvalid_o); end
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
      bad++; $display("FAIL rd_resp got=%b/%h/%b exp=1/deadbeef/0", rvalid_o, rdata_o, err_o); end
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_single got=%b exp=0", rvalid_o); end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    req_i = 1; we_i = 1; addr_i = 32'h10; be_i = 4'b0010; wdata_i = 32'h0000_AB00; #1;
    total++; if (bram_we_a !== 4'b0010 || bram_en_a !== 1'b1) begin bad++; $display("FAIL bw_strobe got=%b/%b exp=0010/1", bram_we_a, bram_en_a); end
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin bad++; $display("FAIL bw_resp got=%b/%h exp=1/0", rvalid_o, rdata_o); end
    // Misaligned read of the same word: low address bits must be ignored
    req_i = 1; addr_i = 32'h13; #1;
    total++; if (bram_addr_a !== 16'h0010) begin bad++; $display("FAIL bw_align got=%h exp=0010", bram_addr_a); end
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1122_AB44) begin bad++; $display("FAIL bw_readback got=%b/%h exp=1/1122ab44", rvalid_o, rdata_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hDEAD_BEEF};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_i = (i < 4); we_i = 0; addr_i = 32'(i * 4); #1;
      if (i < 4) begin
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, gnt_o); end
      end
      if (i >= 2 && i < 6) begin
        total++; if (rvalid_o !== 1'b1 || rdata_o !== exp[i-2]) begin bad++; $display("FAIL b2b_resp[%0d] got=%b/%h exp=1/%h", i, rvalid_o, rdata_o, exp[i-2]); end
      end else begin
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL b2b_quiet[%0d] got=%b exp=0", i, rvalid_o); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_window();
    @(negedge clk);
    req_i = 1; we_i = 0; addr_i = 32'h0001_0000; #1;
    total++; if (gnt_o !== 1'b1 || bram_en_a !== 1'b0) begin bad++; $display("FAIL oow_issue got=%b/%b exp=1/0", gnt_o, bram_en_a); end
    @(negedge clk);
    we_i = 1; be_i = 4'hF; addr_i = 32'hFFFF_0000; #1;
    total++; if (bram_en_a !== 1'b0 || bram_we_a !== 4'h0) begin bad++; $display("FAIL oow_write got=%b/%h exp=0/0", bram_en_a, bram_we_a); end
    @(negedge clk);
    we_i = 0; be_i = 4'h0; addr_i = 32'h0000_FFFC; #1;
    total++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin bad++; $display("FAIL oow_resp got=%b/%b/%h exp=1/1/0", rvalid_o, err_o, rdata_o); end
    total++; if (bram_en_a !== 1'b1 || bram_addr_a !== 16'hFFFC) begin bad++; $display("FAIL top_addr got=%b/%h exp=1/fffc", bram_en_a, bram_addr_a); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin bad++; $display("FAIL oow_wresp got=%b/%b exp=1/1", rvalid_o, err_o); end
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("FAIL top_resp got=%b/%b exp=1/0", rvalid_o, err_o); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall_i = 1; req_i = 1; we_i = 0; addr_i = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (gnt_o !== 1'b0 || bram_en_a !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got=%b/%b exp=0/0", i, gnt_o, bram_en_a); end
      @(negedge clk);
    end
    stall_i = 0; #1;
    total++; if (gnt_o !== 1'b1 || bram_en_a !== 1'b1) begin bad++; $display("FAIL stall_release got=%b/%b exp=1/1", gnt_o, bram_en_a); end
    @(negedge clk);
    stall_i = 1; #1;
    total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL stall_mid got=%b exp=0", gnt_o); end
    @(negedge clk); #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stall_inflight got=%b/%h exp=1/deadbeef", rvalid_o, rdata_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    @(negedge clk);
    req_i = 1; we_i = 0; addr_i = 32'hC; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", gnt_o); end
    @(negedge clk);
    idle_inputs(); reset = 1; #1;
    total++; if (bram_addr_a !== 16'h0 || bram_rst_a !== 1'b0) begin bad++; $display("FAIL mid_rst_cycle got=%h/%b exp=0000/0", bram_addr_a, bram_rst_a); end
    @(negedge clk);
    reset = 0; #1;
    total++; if (bram_rst_a !== 1'b1) begin bad++; $display("FAIL mid_bram_rst got=%b exp=1", bram_rst_a); end
    if (rvalid_o) seen++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rvalid_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_dropped got=%0d exp=0", seen); end
    test_read();
  endtask

  initial begin
    test_reset();
    test_full_writes();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_window();
    test_stall();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
